// File: rtl/div.sv
// Iterative 32-bit radix-2 restoring divider. It answers the EX-stage start/done handshake
// with a registered {remainder, quotient}. Division by zero returns an all-ones quotient and passes the dividend through as the remainder.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div_data1_i,
    input  logic [31:0] div_data2_i,
    input  logic        div_signed_i,
    input  logic        div_start_i,
    input  logic        div_cancel_i,
    output logic [63:0] div_result_o,
    output logic        div_done_o,
    output logic        div_busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        sgn_q, sgn_d;
    logic        neg_dvd_q, neg_dvd_d;
    logic        neg_dvs_q, neg_dvs_d;
    logic [63:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [31:0] abs1, abs2;
    logic [32:0] shifted, trial, rem_iter;
    logic [31:0] quo_iter, q_fix, r_fix;
    logic        fits;

    assign abs1 = (div_signed_i && div_data1_i[31]) ? -div_data1_i : div_data1_i;
    assign abs2 = (div_signed_i && div_data2_i[31]) ? -div_data2_i : div_data2_i;

    // quo_q holds the dividend magnitude and collects quotient bits as it shifts out.
    // Shifted is always below twice the divisor, so bit 32 of the trial difference is its sign.
    assign shifted  = {rem_q[31:0], quo_q[31]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign fits     = ~trial[32];
    assign rem_iter = fits ? trial : shifted;
    assign quo_iter = {quo_q[30:0], fits};

    assign q_fix = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? -quo_iter : quo_iter;
    assign r_fix = (sgn_q && neg_dvd_q) ? -rem_iter[31:0] : rem_iter[31:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sgn_d     = sgn_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        result_d  = result_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!div_cancel_i && div_start_i) begin
                    if (div_data2_i == 32'd0) begin
                        result_d = {div_data1_i, 32'hFFFF_FFFF};
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        quo_d     = abs1;
                        dvs_d     = abs2;
                        sgn_d     = div_signed_i;
                        neg_dvd_d = div_data1_i[31];
                        neg_dvs_d = div_data2_i[31];
                        rem_d     = 33'd0;
                        cnt_d     = 5'd0;
                        busy_d    = 1'b1;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (div_cancel_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_iter;
                    quo_d = quo_iter;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = {r_fix, q_fix};
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            sgn_q     <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= 64'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sgn_q     <= sgn_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign div_result_o = result_q;
    assign div_done_o   = done_q;
    assign div_busy_o   = busy_q;

endmodule
